// File: rtl/wjx1_dec_seq_pkg.sv
// rtl/wjx1_dec_seq_pkg.sv - shared WJX1 core defines: prefix marker and issue-sequencer state encodings
package wjx1_dec_seq_pkg;

  localparam logic [7:0] WJX1_PFX_MARK = 8'h8E;

  localparam logic [1:0] DSQ_ST_EMPTY = 2'd0;
  localparam logic [1:0] DSQ_ST_ISSUE = 2'd1;
  localparam logic [1:0] DSQ_ST_HOLD  = 2'd2;
  localparam logic [1:0] DSQ_ST_FLUSH = 2'd3;

  typedef enum logic [1:0] {
    ST_EMPTY = DSQ_ST_EMPTY,
    ST_ISSUE = DSQ_ST_ISSUE,
    ST_HOLD  = DSQ_ST_HOLD,
    ST_FLUSH = DSQ_ST_FLUSH
  } dsq_state_e;

  function automatic logic is_prefix(input logic [15:0] half);
    return half[15:8] == WJX1_PFX_MARK;
  endfunction

endpackage

// File: rtl/wjx1_dec_seq_len.sv
// rtl/wjx1_dec_seq_len.sv - combinational length/prefix/trap extractor for a 32-bit fetch window
// Prefix handling is enabled by WJX1_DECSEQ_PFX_EN; otherwise every window is a 16-bit word.
module wjx1_dec_seq_len
  import wjx1_dec_seq_pkg::*;
(
  input  logic [31:0] fetch_word_i,
  output logic [23:0] word_o,
  output logic [2:0]  step_o,
  output logic        trap_o
);

  logic [15:0] h0;
  logic [15:0] h1;

  assign h0 = fetch_word_i[15:0];
  assign h1 = fetch_word_i[31:16];

`ifdef WJX1_DECSEQ_PFX_EN
  // A second marker in the payload is still issued as one 4-byte word, flagged as malformed.
  always_comb begin
    word_o = {8'h00, h0};
    step_o = 3'd2;
    trap_o = 1'b0;
    if (is_prefix(h0)) begin
      word_o = {h0[7:0], h1};
      step_o = 3'd4;
      trap_o = is_prefix(h1);
    end
  end
`else
  logic unused_h1;

  assign unused_h1 = ^h1;
  assign word_o    = {8'h00, h0};
  assign step_o    = 3'd2;
  assign trap_o    = 1'b0;
`endif

endmodule

// File: rtl/wjx1_dec_seq.sv
// rtl/wjx1_dec_seq.sv - WJX1 issue sequencer: splits fetch windows, drives istrWord, tracks hold/flush
// Optional prefix support selected by WJX1_DECSEQ_PFX_EN (see wjx1_dec_seq_len).
module wjx1_dec_seq
  import wjx1_dec_seq_pkg::*;
#(
  parameter logic decTwoStage = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fetchWord,
  input  logic        fetchValid,
  input  logic [31:0] fetchPc,
  output logic        fetchReady,
  output logic [2:0]  fetchStep,
  output logic [23:0] istrWord,
  input  logic        exHold,
  input  logic        flush,
  output logic        idValid,
  output logic [31:0] idPc,
  output logic        idTrap
);

  dsq_state_e  state_q, state_d;
  logic [23:0] word_b_q;
  logic [31:0] pc_b_q;
  logic        v_b_q;
  logic        trap_b_q;

  logic [23:0] a_word;
  logic [2:0]  a_step;
  logic        a_trap;

  wjx1_dec_seq_len u_len (
    .fetch_word_i (fetchWord),
    .word_o       (a_word),
    .step_o       (a_step),
    .trap_o       (a_trap)
  );

  assign fetchStep = a_step;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetchReady = fetchValid & ~exHold & ~flush & (state_q != ST_FLUSH);
    istrWord   = 24'h0;
    // Decoders have no enable, so a held word must be re-driven to keep their outputs stable.
    if (exHold && v_b_q) begin
      istrWord = word_b_q;
    end else if (fetchValid) begin
      istrWord = a_word;
    end
    case (state_q)
      ST_EMPTY: if (fetchReady) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (exHold)          state_d = ST_HOLD;
        else if (!fetchReady) state_d = ST_EMPTY;
      end
      ST_HOLD: begin
        if (!exHold) state_d = fetchReady ? ST_ISSUE : ST_EMPTY;
      end
      ST_FLUSH: state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_FLUSH;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_b_q <= 24'h0;
      pc_b_q   <= 32'h0;
      v_b_q    <= 1'b0;
      trap_b_q <= 1'b0;
    end else if (flush) begin
      v_b_q    <= 1'b0;
      trap_b_q <= 1'b0;
    end else if (!exHold) begin
      word_b_q <= a_word;
      pc_b_q   <= fetchPc;
      v_b_q    <= fetchReady;
      trap_b_q <= a_trap & fetchReady;
    end
  end

  assign idValid = decTwoStage ? v_b_q    : fetchReady;
  assign idPc    = decTwoStage ? pc_b_q   : (fetchReady ? fetchPc : 32'h0);
  assign idTrap  = decTwoStage ? trap_b_q : (fetchReady & a_trap);

endmodule
